dino_sprite_renderer: RTL

- Requester side of the dino sprite ROM interface.
- Per pixel clock, converts the VGA beam position and the dino screen position into the 6-bit ROM counter {row, col}, and drives the 3-bit player state.
- Samples the returned sprite colour bit and registers the final o_pixel_on for the video mixer.
- Owns the player-state/animation FSM; state changes only at frame boundaries, so a sprite never tears mid-frame.

---
 rtl/dino_pkg.sv | 17 +
 rtl/dino_anim_fsm.sv | 101 ++++++++++
 rtl/dino_sprite_renderer.sv | 81 ++++++++
 3 files changed

// File: rtl/dino_pkg.sv
// Shared constants and player-state encoding for the dino sprite renderer
// and its animation FSM.
package dino_pkg;

    localparam int SPRITE_DIM = 8;
    localparam int ROM_CTR_W  = 6;

    typedef enum logic [2:0] {
        RESTART   = 3'b000,
        JUMPING   = 3'b001,
        RUNNING_1 = 3'b010,
        RUNNING_2 = 3'b011,
        DUCKING   = 3'b100,
        GAME_OVER = 3'b101
    } player_state_e;

endpackage

// File: rtl/dino_anim_fsm.sv
// Player-state / run-animation FSM; advances only on frame ticks.
// Optional GAME_OVER blink counter enabled by DINO_RENDER_BLINK_EN.
module dino_anim_fsm
    import dino_pkg::*;
#(
    parameter int ANIM_FRAMES = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          start,
    input  logic          airborne,
    input  logic          duck,
    input  logic          collision,
    output player_state_e state,
    output logic          blank
);

    localparam logic [5:0] ANIM_LAST = 6'(ANIM_FRAMES - 1);

    player_state_e state_q, state_d;
    logic [5:0]    anim_q, anim_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESTART;
            anim_q  <= '0;
        end else begin
            state_q <= state_d;
            anim_q  <= anim_d;
        end
    end

    // Any transition that is not a pure run continuation restarts the
    // animation count, so every entry into running begins a full period.
    always_comb begin
        state_d = state_q;
        anim_d  = anim_q;
        if (tick) begin
            case (state_q)
                RESTART: begin
                    if (start) begin
                        state_d = RUNNING_1;
                        anim_d  = '0;
                    end
                end
                RUNNING_1, RUNNING_2, JUMPING, DUCKING: begin
                    anim_d = '0;
                    if (collision) begin
                        state_d = GAME_OVER;
                    end else if (airborne) begin
                        state_d = JUMPING;
                    end else if (duck) begin
                        state_d = DUCKING;
                    end else if (state_q == JUMPING || state_q == DUCKING) begin
                        state_d = RUNNING_1;
                    end else if (anim_q == ANIM_LAST) begin
                        if (state_q == RUNNING_1) begin
                            state_d = RUNNING_2;
                        end else begin
                            state_d = RUNNING_1;
                        end
                    end else begin
                        anim_d = anim_q + 6'd1;
                    end
                end
                GAME_OVER: begin
                    if (start) begin
                        state_d = RESTART;
                        anim_d  = '0;
                    end
                end
                default: begin
                    state_d = RESTART;
                    anim_d  = '0;
                end
            endcase
        end
    end

    assign state = state_q;

`ifdef DINO_RENDER_BLINK_EN
    logic [2:0] blink_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q <= '0;
        end else if (state_q != GAME_OVER) begin
            blink_q <= '0;
        end else if (tick) begin
            blink_q <= blink_q + 3'd1;
        end
    end

    assign blank = (state_q == GAME_OVER) && blink_q[2];
`else
    assign blank = 1'b0;
`endif

endmodule

// File: rtl/dino_sprite_renderer.sv
// Dino sprite requester: beam-to-ROM address mapping, 2-stage pixel pipeline
// and animation FSM. Optional GAME_OVER blink via DINO_RENDER_BLINK_EN.
module dino_sprite_renderer
    import dino_pkg::*;
#(
    parameter int SCALE_LOG2  = 2,
    parameter int ANIM_FRAMES = 6,
    parameter int POS_W       = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [POS_W-1:0]     i_hpos,
    input  logic [POS_W-1:0]     i_vpos,
    input  logic                 i_frame_tick,
    input  logic [POS_W-1:0]     i_sprite_x,
    input  logic [POS_W-1:0]     i_sprite_y,
    input  logic                 i_start,
    input  logic                 i_airborne,
    input  logic                 i_duck,
    input  logic                 i_collision,
    output logic [ROM_CTR_W-1:0] o_rom_counter,
    output logic [2:0]           o_player_state,
    input  logic                 i_sprite_color,
    output logic                 o_pixel_on
);

    localparam logic [POS_W-1:0] WIN_SIZE = POS_W'(SPRITE_DIM << SCALE_LOG2);

    player_state_e state;
    logic          blank;

    dino_anim_fsm #(
        .ANIM_FRAMES(ANIM_FRAMES)
    ) u_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (i_frame_tick),
        .start    (i_start),
        .airborne (i_airborne),
        .duck     (i_duck),
        .collision(i_collision),
        .state    (state),
        .blank    (blank)
    );

    assign o_player_state = state;

    // No handshake: every pixel clock carries a valid beam position, and
    // o_pixel_on always refers to the position presented two cycles earlier.
    logic [POS_W-1:0] dx, dy;
    logic             in_win;
    logic [2:0]       rom_x, rom_y;

    // Modulo subtraction makes a beam left of / above the sprite huge.
    assign dx     = i_hpos - i_sprite_x;
    assign dy     = i_vpos - i_sprite_y;
    assign in_win = (dx < WIN_SIZE) && (dy < WIN_SIZE);
    assign rom_y  = dy[SCALE_LOG2 +: 3];
    assign rom_x  = 3'd7 - dx[SCALE_LOG2 +: 3];

    logic win_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rom_counter <= '0;
            win_q         <= 1'b0;
        end else begin
            o_rom_counter <= in_win ? {rom_y, rom_x} : '0;
            win_q         <= in_win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_pixel_on <= 1'b0;
        end else begin
            o_pixel_on <= win_q & i_sprite_color & ~blank;
        end
    end

endmodule
